pipe_hazard_ctrl: RTL

Parametrised hazard, forwarding and stage-control unit for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB). It sits beside the instruction decoder. It takes register-use information for the ID-stage instruction and write-back information from a configurable number of downstream producer stages, and generates:
- forwarding selects and stall/flush/enable signals for every stage;
- interrupt-entry/ERET sequencing through a small state machine;
- stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_ctrl_fwd_match.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared constants for the pipeline hazard / forwarding / stage-control block.
//   - Stage bit positions used in the stage_en / stage_rst vectors (IF..WB).
//   - Interrupt FSM state encoding (RUN, ISR).
//   - Forwarding select base value (FWD_RF selects the register file).
//   - Helper returning a one-hot stage mask.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int NUM_STG = 5;

    // All five stages at once, used for full freeze / full reset.
    localparam logic [NUM_STG-1:0] STG_ALL  = 5'b11111;
    localparam logic [NUM_STG-1:0] STG_NONE = 5'b00000;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        ISR = 1'b1
    } hz_state_e;

    // One-hot mask for a single stage index.
    function automatic logic [NUM_STG-1:0] stg_bit(input int idx);
        logic [NUM_STG-1:0] mask;
        mask = STG_NONE;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the instruction decoder side (master) and the hazard
// controller (slave).
//   Decoder -> controller : ID register use, producer write-back info,
//                           cache stalls, jump, irq, ERET.
//   Controller -> decoder : forwarding selects, per-stage enable / reset,
//                           irq_take pulse, ir_en, perf counters.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int NUM_PROD = 3,
    parameter int SEL_W    = $clog2(NUM_PROD + 1),
    parameter int CNT_W    = 32
);
    logic [4:0]            id_rs_addr;
    logic [4:0]            id_rt_addr;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [NUM_PROD-1:0]   prod_wen;
    logic [5*NUM_PROD-1:0] prod_addr;
    logic [NUM_PROD-1:0]   prod_is_load;
    logic                  icache_stall;
    logic                  dcache_stall;
    logic                  jump_en;
    logic                  irq;
    logic                  eret_id;

    logic [SEL_W-1:0]      fwd_a;
    logic [SEL_W-1:0]      fwd_b;
    logic [4:0]            stage_en;
    logic [4:0]            stage_rst;
    logic                  irq_take;
    logic                  ir_en;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               prod_wen, prod_addr, prod_is_load,
               icache_stall, dcache_stall, jump_en, irq, eret_id,
        input  fwd_a, fwd_b, stage_en, stage_rst, irq_take, ir_en,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               prod_wen, prod_addr, prod_is_load,
               icache_stall, dcache_stall, jump_en, irq, eret_id,
        output fwd_a, fwd_b, stage_en, stage_rst, irq_take, ir_en,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Priority match of one ID source register against NUM_PROD producers.
//   i_src_addr / i_src_used : source register of the ID instruction
//   i_prod_wen / i_prod_addr / i_prod_is_load : producer k write-back info,
//                             address of producer k in bits [5k+4:5k]
//   o_sel      : 0 = register file, k+1 = youngest matching producer k
//   o_load_hit : source matches a load that is not yet forwardable
//                (producer index below LOAD_READY)
// r0 never matches since it is hard-wired to zero.
// -----------------------------------------------------------------------------
module fwd_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_PROD   = 3,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = $clog2(NUM_PROD + 1)
) (
    input  logic [4:0]            i_src_addr,
    input  logic                  i_src_used,
    input  logic [NUM_PROD-1:0]   i_prod_wen,
    input  logic [5*NUM_PROD-1:0] i_prod_addr,
    input  logic [NUM_PROD-1:0]   i_prod_is_load,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_load_hit
);

    // Producers whose load data is not yet available for forwarding.
    localparam logic [NUM_PROD-1:0] READY_MASK =
        {NUM_PROD{1'b1}} >> (NUM_PROD - LOAD_READY);

    logic                w_src_ok;
    logic [NUM_PROD-1:0] w_match;
    logic [SEL_W-1:0]    w_sel;

    // Per-producer address match against the source register.
    always_comb begin
        w_match  = {NUM_PROD{1'b0}};
        w_src_ok = i_src_used & (i_src_addr != 5'd0);
        for (int k = 0; k < NUM_PROD; k++) begin
            w_match[k] = w_src_ok & i_prod_wen[k] &
                         (i_prod_addr[5*k +: 5] == i_src_addr);
        end
    end

    // Priority select: walk from oldest to youngest so the youngest match wins.
    always_comb begin
        w_sel = SEL_W'(FWD_RF);
        for (int k = NUM_PROD - 1; k >= 0; k--) begin
            w_sel = w_match[k] ? SEL_W'(k + 1) : w_sel;
        end
    end

    assign o_sel      = w_sel;
    assign o_load_hit = |(w_match & i_prod_is_load & READY_MASK);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard, forwarding and stage-control unit for the 5-stage pipeline.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pipe_hazard_ctrl_if.slave (decoder inputs, control outputs)
// Stage control is a strict priority table:
//   reset > D-cache freeze > I-cache / load-use bubble > interrupt entry
//   > ERET return > taken jump.
// A small RUN/ISR state machine sequences interrupt entry and ERET; two
// wrapping counters record stall and flush cycles.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_PROD   = 3,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = $clog2(NUM_PROD + 1),
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    logic [SEL_W-1:0]   w_sel_a;
    logic [SEL_W-1:0]   w_sel_b;
    logic               w_hit_a;
    logic               w_hit_b;
    logic               w_load_use;
    logic               w_blocked;
    logic               w_take;
    logic               w_eret_go;
    logic [NUM_STG-1:0] w_stage_en;
    logic [NUM_STG-1:0] w_stage_rst;
    logic               w_stall_row;
    logic               w_flush_row;
    hz_state_e          r_state;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    fwd_match #(
        .NUM_PROD   (NUM_PROD),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_fwd_rs (
        .i_src_addr     (bus.id_rs_addr),
        .i_src_used     (bus.id_rs_used),
        .i_prod_wen     (bus.prod_wen),
        .i_prod_addr    (bus.prod_addr),
        .i_prod_is_load (bus.prod_is_load),
        .o_sel          (w_sel_a),
        .o_load_hit     (w_hit_a)
    );

    fwd_match #(
        .NUM_PROD   (NUM_PROD),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_fwd_rt (
        .i_src_addr     (bus.id_rt_addr),
        .i_src_used     (bus.id_rt_used),
        .i_prod_wen     (bus.prod_wen),
        .i_prod_addr    (bus.prod_addr),
        .i_prod_is_load (bus.prod_is_load),
        .o_sel          (w_sel_b),
        .o_load_hit     (w_hit_b)
    );

    assign w_load_use = w_hit_a | w_hit_b;

    // Reset, freeze or bubble all block an FSM transition; it is retried
    // on the first cycle where none of them applies.
    assign w_blocked = rst | bus.dcache_stall | bus.icache_stall | w_load_use;
    assign w_take    = (r_state == RUN) & bus.irq     & ~w_blocked;
    assign w_eret_go = (r_state == ISR) & bus.eret_id & ~w_blocked;

    // Stage enable / reset priority table and the counter event flags.
    always_comb begin
        w_stage_en  = STG_ALL;
        w_stage_rst = STG_NONE;
        w_stall_row = 1'b0;
        w_flush_row = 1'b0;
        if (rst) begin
            w_stage_rst = STG_ALL;
        end else if (bus.dcache_stall) begin
            w_stage_en  = STG_NONE;
            w_stall_row = 1'b1;
        end else if (bus.icache_stall || w_load_use) begin
            // Hold IF/ID and inject a bubble into EXE.
            w_stage_en  = STG_ALL & ~(stg_bit(STG_IF) | stg_bit(STG_ID));
            w_stage_rst = stg_bit(STG_EXE);
            w_stall_row = 1'b1;
            w_flush_row = 1'b1;
        end else if (w_take) begin
            // Squash ID and EXE; the squashed instructions re-execute on return.
            w_stage_rst = stg_bit(STG_ID) | stg_bit(STG_EXE);
            w_flush_row = 1'b1;
        end else if (w_eret_go || bus.jump_en) begin
            w_stage_rst = stg_bit(STG_ID);
            w_flush_row = 1'b1;
        end else begin
            w_stage_en  = STG_ALL;
            w_stage_rst = STG_NONE;
        end
    end

    // Interrupt sequencing state machine (RUN <-> ISR).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     r_state <= w_take    ? ISR : RUN;
                ISR:     r_state <= w_eret_go ? RUN : ISR;
                default: r_state <= RUN;
            endcase
        end
    end

    // Stall / flush performance counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, w_stall_row};
            r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, w_flush_row};
        end
    end

    // Forwarding is meaningless while the ID instruction is being held.
    assign bus.fwd_a     = (rst | w_load_use) ? SEL_W'(FWD_RF) : w_sel_a;
    assign bus.fwd_b     = (rst | w_load_use) ? SEL_W'(FWD_RF) : w_sel_b;
    assign bus.stage_en  = w_stage_en;
    assign bus.stage_rst = w_stage_rst;
    assign bus.irq_take  = w_take;
    assign bus.ir_en     = rst | (r_state == RUN);
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule
